wavegen_multi: RTL and testbench

Parametrised multi-mode waveform generator that supersedes the fixed 4-bit square and triangle generators. It produces sawtooth, square with programmable duty, or full-amplitude triangle from one WIDTH-bit phase counter, with a programmable clock prescaler. Configuration arrives over a valid/ready handshake and takes effect only at a period boundary, so the output never glitches mid-period. It sits in the signal-source layer and feeds DAC/PWM consumers.

---
 rtl/wavegen_pkg.sv | 17 +
 rtl/wavegen_multi_if.sv | 27 ++
 rtl/wavegen_prescaler.sv | 35 +++
 rtl/wavegen_multi.sv | 128 ++++++++++++
 tb/tb_wavegen_multi.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/wavegen_pkg.sv
// rtl/wavegen_pkg.sv - shared mode encoding and reset defaults for the waveform generator
package wavegen_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_SAW      = 2'd0,
        MODE_SQUARE   = 2'd1,
        MODE_TRIANGLE = 2'd2,
        MODE_OFF      = 2'd3
    } mode_e;

    localparam int DIV_RESET = 0;
    // Reset duty is 2^WIDTH >> DUTY_FRAC_SHIFT, i.e. a 50 % square.
    localparam int DUTY_FRAC_SHIFT = 1;

endpackage

// File: rtl/wavegen_multi_if.sv
// rtl/wavegen_multi_if.sv - configuration valid/ready channel of the waveform generator
interface wavegen_multi_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) ();
    logic                          cfg_valid;
    logic                          cfg_ready;
    logic [wavegen_pkg::MODE_W-1:0] cfg_mode;
    logic [DIV_W-1:0]              cfg_div;
    logic [WIDTH-1:0]              cfg_duty;

    modport master (
        output cfg_valid,
        output cfg_mode,
        output cfg_div,
        output cfg_duty,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_mode,
        input  cfg_div,
        input  cfg_duty,
        output cfg_ready
    );
endinterface

// File: rtl/wavegen_prescaler.sv
// rtl/wavegen_prescaler.sv - divide-by-(div+1) sample tick generator with synchronous clear
module wavegen_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] presc_q;
    logic [DIV_W-1:0] presc_d;

    assign tick = en && (presc_q == div);

    always_comb begin
        presc_d = presc_q;
        if (clr || tick) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/wavegen_multi.sv
// rtl/wavegen_multi.sv - saw/square/triangle generator with period-boundary reconfiguration
module wavegen_multi
    import wavegen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    wavegen_multi_if.slave   cfg,
    output logic [WIDTH-1:0] wave,
    output logic             sample_tick,
    output logic             period_start
);

    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DIV_RESET);
    localparam logic [WIDTH-1:0] DUTY_RST = WIDTH'(1) << (WIDTH - DUTY_FRAC_SHIFT);

    function automatic logic [WIDTH-1:0] shape(input mode_e m, input logic [WIDTH-1:0] p,
                                               input logic [WIDTH-1:0] duty);
        logic [WIDTH-1:0] s;
        s = {p[WIDTH-2:0], 1'b0};
        case (m)
            MODE_SAW:      shape = p;
            MODE_SQUARE:   shape = (p < duty) ? '1 : '0;
            MODE_TRIANGLE: shape = p[WIDTH-1] ? ~s : s;
            default:       shape = '0;
        endcase
    endfunction

    mode_e            mode_q, mode_d, pend_mode_q, pend_mode_d;
    logic [DIV_W-1:0] div_q, div_d, pend_div_q, pend_div_d;
    logic [WIDTH-1:0] duty_q, duty_d, pend_duty_q, pend_duty_d;
    logic [WIDTH-1:0] ph_q, ph_d, wave_q, wave_d;
    logic             pend_v_q, pend_v_d;
    logic             sample_tick_q, sample_tick_d;
    logic             period_start_q, period_start_d;
    logic             tick, wrap, apply, presc_clr;
    logic [WIDTH-1:0] ph_inc;

    wavegen_prescaler #(.DIV_W(DIV_W)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (presc_clr),
        .div  (div_q),
        .tick (tick)
    );

    assign ph_inc = ph_q + 1'b1;
    assign wrap   = tick && (ph_q == '1);
    // While running, a pending config waits for the wrap; while stopped it lands immediately.
    assign apply  = pend_v_q && (en ? wrap : 1'b1);

    always_comb begin
        mode_d         = mode_q;
        div_d          = div_q;
        duty_d         = duty_q;
        ph_d           = ph_q;
        wave_d         = wave_q;
        pend_v_d       = pend_v_q;
        pend_mode_d    = pend_mode_q;
        pend_div_d     = pend_div_q;
        pend_duty_d    = pend_duty_q;
        sample_tick_d  = tick;
        period_start_d = wrap;
        presc_clr      = 1'b0;

        if (tick) begin
            ph_d   = ph_inc;
            wave_d = shape(mode_q, ph_inc, duty_q);
        end

        if (apply) begin
            mode_d   = pend_mode_q;
            div_d    = pend_div_q;
            duty_d   = pend_duty_q;
            pend_v_d = 1'b0;
            ph_d     = '0;
            wave_d   = shape(pend_mode_q, '0, pend_duty_q);
            if (!en) begin
                presc_clr = 1'b1;
            end
        end

        if (cfg.cfg_valid && !pend_v_q) begin
            pend_v_d    = 1'b1;
            pend_mode_d = mode_e'(cfg.cfg_mode);
            pend_div_d  = cfg.cfg_div;
            pend_duty_d = cfg.cfg_duty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q         <= MODE_SAW;
            div_q          <= DIV_RST;
            duty_q         <= DUTY_RST;
            ph_q           <= '0;
            wave_q         <= '0;
            pend_v_q       <= 1'b0;
            pend_mode_q    <= MODE_SAW;
            pend_div_q     <= '0;
            pend_duty_q    <= '0;
            sample_tick_q  <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            mode_q         <= mode_d;
            div_q          <= div_d;
            duty_q         <= duty_d;
            ph_q           <= ph_d;
            wave_q         <= wave_d;
            pend_v_q       <= pend_v_d;
            pend_mode_q    <= pend_mode_d;
            pend_div_q     <= pend_div_d;
            pend_duty_q    <= pend_duty_d;
            sample_tick_q  <= sample_tick_d;
            period_start_q <= period_start_d;
        end
    end

    assign cfg.cfg_ready = ~pend_v_q;
    assign wave          = wave_q;
    assign sample_tick   = sample_tick_q;
    assign period_start  = period_start_q;

endmodule

// File: tb/tb_wavegen_multi.sv
// tb/tb_wavegen_multi.sv - directed self-checking bench for wavegen_multi
module tb_wavegen_multi;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] wave;
    logic       sample_tick;
    logic       period_start;

    int checks;
    int passed;

    wavegen_multi_if #(.WIDTH(8), .DIV_W(8)) cfg_if ();

    wavegen_multi #(.WIDTH(8), .DIV_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg          (cfg_if),
        .wave         (wave),
        .sample_tick  (sample_tick),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_run(input logic en_val);
        rst = 1'b1;
        en  = en_val;
        cfg_if.cfg_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (wave !== 8'd0) $display("FAIL reset_wave: got %0d want 0", wave); else passed++;
        checks++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cfg_if.cfg_ready); else passed++;
        checks++; if (sample_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", sample_tick); else passed++;
        checks++; if (period_start !== 1'b0) $display("FAIL reset_pstart: got %b want 0", period_start); else passed++;
    endtask

    task automatic test_saw_default;
        logic [7:0] exp_w;
        start_run(1'b1);
        for (int k = 1; k <= 520; k++) begin
            @(negedge clk);
            exp_w = 8'(k % 256);
            checks++; if (wave !== exp_w) $display("FAIL saw_wave k=%0d: got %0d want %0d", k, wave, exp_w); else passed++;
            checks++; if (sample_tick !== 1'b1) $display("FAIL saw_tick k=%0d: got %b want 1", k, sample_tick); else passed++;
            checks++; if (period_start !== (exp_w == 8'd0)) $display("FAIL saw_pstart k=%0d: got %b want %b", k, period_start, exp_w == 8'd0); else passed++;
        end
    endtask

    task automatic test_square_div;
        logic [7:0] exp_w;
        int         p;
        start_run(1'b0);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_mode  = 2'd1;
        cfg_if.cfg_div   = 8'd1;
        cfg_if.cfg_duty  = 8'd64;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        checks++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL sq_ready_low: got %b want 0", cfg_if.cfg_ready); else passed++;
        @(negedge clk);
        checks++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL sq_ready_high: got %b want 1", cfg_if.cfg_ready); else passed++;
        checks++; if (wave !== 8'd255) $display("FAIL sq_apply_wave: got %0d want 255", wave); else passed++;
        checks++; if (period_start !== 1'b0) $display("FAIL sq_apply_pstart: got %b want 0", period_start); else passed++;
        checks++; if (sample_tick !== 1'b0) $display("FAIL sq_apply_tick: got %b want 0", sample_tick); else passed++;
        en = 1'b1;
        for (int n = 1; n <= 520; n++) begin
            @(negedge clk);
            p = (n / 2) % 256;
            exp_w = (p < 64) ? 8'd255 : 8'd0;
            checks++; if (wave !== exp_w) $display("FAIL sq_wave n=%0d: got %0d want %0d", n, wave, exp_w); else passed++;
            checks++; if (sample_tick !== (n % 2 == 0)) $display("FAIL sq_tick n=%0d: got %b want %b", n, sample_tick, n % 2 == 0); else passed++;
            checks++; if (period_start !== (n % 2 == 0 && p == 0)) $display("FAIL sq_pstart n=%0d: got %b want %b", n, period_start, n % 2 == 0 && p == 0); else passed++;
        end
        en = 1'b0;
    endtask

    task automatic test_triangle;
        logic [7:0] exp_w;
        start_run(1'b0);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_mode  = 2'd2;
        cfg_if.cfg_div   = 8'd0;
        cfg_if.cfg_duty  = 8'd0;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        @(negedge clk);
        checks++; if (wave !== 8'd0) $display("FAIL tri_p0: got %0d want 0", wave); else passed++;
        en = 1'b1;
        for (int n = 1; n <= 255; n++) begin
            @(negedge clk);
            exp_w = (n < 128) ? 8'(2 * n) : 8'(511 - 2 * n);
            checks++; if (wave !== exp_w) $display("FAIL tri_wave p=%0d: got %0d want %0d", n, wave, exp_w); else passed++;
            if (n == 127) begin
                checks++; if (wave !== 8'd254) $display("FAIL tri_p127: got %0d want 254", wave); else passed++;
            end
            if (n == 128) begin
                checks++; if (wave !== 8'd255) $display("FAIL tri_p128: got %0d want 255", wave); else passed++;
            end
            if (n == 255) begin
                checks++; if (wave !== 8'd1) $display("FAIL tri_p255: got %0d want 1", wave); else passed++;
            end
        end
        en = 1'b0;
    endtask

    task automatic test_reconfig_at_wrap;
        start_run(1'b1);
        repeat (10) @(negedge clk);
        checks++; if (wave !== 8'd10) $display("FAIL wrap_start: got %0d want 10", wave); else passed++;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_mode  = 2'd2;
        cfg_if.cfg_div   = 8'd0;
        cfg_if.cfg_duty  = 8'd0;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        checks++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL wrap_ready_low: got %b want 0", cfg_if.cfg_ready); else passed++;
        checks++; if (wave !== 8'd11) $display("FAIL wrap_k11: got %0d want 11", wave); else passed++;
        for (int k = 12; k <= 255; k++) begin
            @(negedge clk);
            checks++; if (wave !== 8'(k)) $display("FAIL wrap_saw k=%0d: got %0d want %0d", k, wave, k); else passed++;
            checks++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL wrap_ready_hold k=%0d: got %b want 0", k, cfg_if.cfg_ready); else passed++;
        end
        @(negedge clk);
        checks++; if (wave !== 8'd0) $display("FAIL wrap_wave0: got %0d want 0", wave); else passed++;
        checks++; if (period_start !== 1'b1) $display("FAIL wrap_pstart: got %b want 1", period_start); else passed++;
        checks++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL wrap_ready_back: got %b want 1", cfg_if.cfg_ready); else passed++;
        @(negedge clk);
        checks++; if (wave !== 8'd2) $display("FAIL wrap_tri1: got %0d want 2", wave); else passed++;
        checks++; if (period_start !== 1'b0) $display("FAIL wrap_pstart_off: got %b want 0", period_start); else passed++;
        @(negedge clk);
        checks++; if (wave !== 8'd4) $display("FAIL wrap_tri2: got %0d want 4", wave); else passed++;
    endtask

    task automatic test_en_freeze;
        start_run(1'b1);
        repeat (100) @(negedge clk);
        checks++; if (wave !== 8'd100) $display("FAIL frz_start: got %0d want 100", wave); else passed++;
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++; if (wave !== 8'd100) $display("FAIL frz_wave i=%0d: got %0d want 100", i, wave); else passed++;
            checks++; if (sample_tick !== 1'b0) $display("FAIL frz_tick i=%0d: got %b want 0", i, sample_tick); else passed++;
        end
        en = 1'b1;
        @(negedge clk);
        checks++; if (wave !== 8'd101) $display("FAIL frz_resume: got %0d want 101", wave); else passed++;
        checks++; if (sample_tick !== 1'b1) $display("FAIL frz_resume_tick: got %b want 1", sample_tick); else passed++;
    endtask

    task automatic test_async_reset;
        start_run(1'b1);
        repeat (50) @(negedge clk);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_mode  = 2'd3;
        cfg_if.cfg_div   = 8'd5;
        cfg_if.cfg_duty  = 8'd0;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        checks++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL arst_pending: got %b want 0", cfg_if.cfg_ready); else passed++;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (wave !== 8'd0) $display("FAIL arst_wave: got %0d want 0", wave); else passed++;
        checks++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL arst_ready: got %b want 1", cfg_if.cfg_ready); else passed++;
        checks++; if (sample_tick !== 1'b0) $display("FAIL arst_tick: got %b want 0", sample_tick); else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++; if (wave !== 8'(k)) $display("FAIL arst_saw k=%0d: got %0d want %0d", k, wave, k); else passed++;
            checks++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL arst_ready_k k=%0d: got %b want 1", k, cfg_if.cfg_ready); else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst = 1'b1;
        en  = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_mode  = 2'd0;
        cfg_if.cfg_div   = 8'd0;
        cfg_if.cfg_duty  = 8'd0;
        test_reset();
        test_saw_default();
        test_square_div();
        test_triangle();
        test_reconfig_at_wrap();
        test_en_freeze();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
